// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: system-clock-side controller for the Raspberry Pi SPI slave.
// Round-robin arbitration of NUM_REQ requesters for the outgoing frame word.
// Received frames are presented as a one-cycle strobe with a frame counter.
// The word driven on spi_tx never changes while a frame is being shifted.
// Optional build macro SPI_ARB_ECHO_EN: the filler word is the last received
// frame (loopback echo) instead of the constant IDLE_WORD.
module spi_frame_arbiter #(
  parameter int unsigned            DATA_LENGTH = 64,
  parameter int unsigned            NUM_REQ     = 4,
  parameter logic [DATA_LENGTH-1:0] IDLE_WORD   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           spi_cs,
  input  logic                           spi_ready,
  input  logic [DATA_LENGTH-1:0]         spi_rx,
  output logic [DATA_LENGTH-1:0]         spi_tx,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           rx_valid,
  output logic [DATA_LENGTH-1:0]         rx_data,
  output logic [15:0]                    frame_count,
  output logic                           busy
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   cs_meta_q;
  logic                   cs_s_q;
  logic                   rdy_meta_q;
  logic                   rdy_s_q;
  logic                   rdy_dly_q;
  logic                   rdy_rise;
  logic [GW-1:0]          last_grant_q;
  logic [GW-1:0]          grant_idx;
  logic [GW-1:0]          cand;
  logic                   grant_any;
  logic [DATA_LENGTH-1:0] grant_word;
  logic [DATA_LENGTH-1:0] idle_fill;
  logic [DATA_LENGTH-1:0] frame_fill;
  logic [DATA_LENGTH-1:0] spi_tx_q;
  logic [DATA_LENGTH-1:0] rx_data_q;
  logic [NUM_REQ-1:0]     req_ack_q;
  logic                   rx_valid_q;
  logic                   owned_q;
  logic                   sent_q;
  logic                   busy_q;
  logic [15:0]            frame_count_q;

  assign spi_tx      = spi_tx_q;
  assign req_ack     = req_ack_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

  // Filler word: used in IDLE and after the first frame of a CS window.
`ifdef SPI_ARB_ECHO_EN
  assign idle_fill  = rx_data_q;
  assign frame_fill = spi_rx;
`else
  assign idle_fill  = IDLE_WORD;
  assign frame_fill = IDLE_WORD;
`endif

  assign rdy_rise = rdy_s_q & ~rdy_dly_q;

  // Two-flop synchronizers for chip select and frame-ready, plus ready edge delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q  <= 1'b1;
      cs_s_q     <= 1'b1;
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      rdy_dly_q  <= 1'b0;
    end else begin
      cs_meta_q  <= spi_cs;
      cs_s_q     <= cs_meta_q;
      rdy_meta_q <= spi_ready;
      rdy_s_q    <= rdy_meta_q;
      rdy_dly_q  <= rdy_s_q;
    end
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the winning requester's word from the packed data bus.
  always_comb begin
    grant_word = IDLE_WORD;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == GW'(i)) begin
        grant_word = req_data[i*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  // Frame FSM: grant in IDLE, hold the word in LOADED, count frames in ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      spi_tx_q      <= IDLE_WORD;
      req_ack_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      frame_count_q <= '0;
      last_grant_q  <= GW'(NUM_REQ - 1);
      owned_q       <= 1'b0;
      sent_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      req_ack_q  <= '0;
      rx_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cs_s_q && grant_any) begin
            spi_tx_q     <= grant_word;
            req_ack_q    <= NUM_REQ'(1) << grant_idx;
            last_grant_q <= grant_idx;
            owned_q      <= 1'b1;
            state_q      <= ST_LOADED;
            busy_q       <= 1'b1;
          end else begin
            spi_tx_q <= idle_fill;
            if (!cs_s_q) begin
              owned_q <= 1'b0;
              sent_q  <= 1'b0;
              state_q <= ST_ACTIVE;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_LOADED: begin
          if (!cs_s_q) begin
            sent_q  <= 1'b0;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (rdy_rise) begin
            rx_data_q     <= spi_rx;
            rx_valid_q    <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            sent_q        <= 1'b1;
            if (!sent_q) begin
              spi_tx_q <= frame_fill;
            end
          end
          // A frame completing on the same cycle as CS rising counts as sent,
          // so the window closes to IDLE rather than re-arming the word.
          if (cs_s_q) begin
            if (owned_q && !(sent_q || rdy_rise)) begin
              state_q <= ST_LOADED;
            end else begin
              owned_q <= 1'b0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Self-checking bench for spi_frame_arbiter: models the Pi master and SPI slave
// at the frame level and predicts grants, transmitted words and receive strobes
// from the window-level arbitration rules.
module tb_spi_frame_arbiter;

  localparam int          DL = 64;
  localparam int          NR = 4;
  localparam logic [DL-1:0] IW = '0;

  logic             clk;
  logic             rst;
  logic             spi_cs;
  logic             spi_ready;
  logic [DL-1:0]    spi_rx;
  logic [DL-1:0]    spi_tx;
  logic [NR-1:0]    req_valid;
  logic [NR*DL-1:0] req_data;
  logic [NR-1:0]    req_ack;
  logic             rx_valid;
  logic [DL-1:0]    rx_data;
  logic [15:0]      frame_count;
  logic             busy;

  spi_frame_arbiter #(
    .DATA_LENGTH(DL),
    .NUM_REQ    (NR),
    .IDLE_WORD  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_cs     (spi_cs),
    .spi_ready  (spi_ready),
    .spi_rx     (spi_rx),
    .spi_tx     (spi_tx),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .frame_count(frame_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;
  int          ack_q[$];
  int unsigned rx_pulses;

  // Reference model state (window-level view of the arbiter).
  int          m_last;
  bit          m_owned;
  logic [DL-1:0] m_word;
  logic [15:0]   m_frames;
  logic [DL-1:0] m_last_rx;

  // Record every ack bit and receive strobe between active edges.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (req_ack[i] === 1'b1) ack_q.push_back(i);
    end
    if (rx_valid === 1'b1) rx_pulses++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [DL-1:0] m_fill();
`ifdef SPI_ARB_ECHO_EN
    return m_last_rx;
`else
    return IW;
`endif
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last    = NR - 1;
    m_owned   = 1'b0;
    m_word    = IW;
    m_frames  = '0;
    m_last_rx = '0;
  endtask

  // One complete SPI frame: 4 clk per SCLK, data_ready rises at frame end.
  task automatic run_frame(input logic [DL-1:0] mosi, input logic [DL-1:0] exp_miso,
                           input bit cs_with_ready, input string tag);
    logic [DL-1:0] got;
    bit            stable;
    int            hit;
    repeat (6) tick();
    got    = spi_tx;
    stable = 1'b1;
    repeat (4*DL) begin
      tick();
      if (spi_tx !== got) stable = 1'b0;
    end
    n_total++;
    if (got !== exp_miso) $display("FAIL %s miso: got %h expected %h", tag, got, exp_miso);
    else n_pass++;
    n_total++;
    if (stable !== 1'b1) $display("FAIL %s tx_stable: got changed expected constant word %h", tag, got);
    else n_pass++;
    spi_rx    = mosi;
    spi_ready = 1'b1;
    if (cs_with_ready) spi_cs = 1'b1;
    m_frames  = m_frames + 16'd1;
    m_last_rx = mosi;
    hit = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (rx_valid === 1'b1) hit = (hit == 0) ? c : 99;
      if (c == 3) begin
        n_total++;
        if (rx_data !== mosi) $display("FAIL %s rx_data: got %h expected %h", tag, rx_data, mosi);
        else n_pass++;
        n_total++;
        if (frame_count !== m_frames)
          $display("FAIL %s frame_count: got %0d expected %0d", tag, frame_count, m_frames);
        else n_pass++;
      end
    end
    n_total++;
    if (hit != 3) $display("FAIL %s rx_valid_latency: got cycle %0d (99=multi) expected 3", tag, hit);
    else n_pass++;
    spi_ready = 1'b0;
  endtask

  // One CS-high gap (grant decision) followed by a CS-low window.
  // nframes==0 opens the window without any complete frame.
  task automatic run_window(input int nframes, input logic [DL-1:0] mosi0,
                            input logic [NR-1:0] next_valid, input bit drop,
                            input bit sim_last, input bit new_data, input string tag);
    int            exp_ack;
    int            first_ack;
    int            n_exp;
    logic [DL-1:0] mosi;
    logic [DL-1:0] exp_miso;
    bit            last;
    exp_ack = -1;
    if (!m_owned && req_valid != '0) begin
      exp_ack = rr_pick(m_last, req_valid);
      m_owned = 1'b1;
      m_word  = req_data[exp_ack*DL +: DL];
      m_last  = exp_ack;
    end
    repeat (10) tick();
    first_ack = (ack_q.size() > 0) ? ack_q[0] : -1;
    n_exp     = (exp_ack < 0) ? 0 : 1;
    n_total++;
    if (ack_q.size() != n_exp || first_ack != exp_ack)
      $display("FAIL %s ack: got %0d acks first=%0d expected %0d acks for requester %0d",
               tag, ack_q.size(), first_ack, n_exp, exp_ack);
    else n_pass++;
    ack_q.delete();
    n_total++;
    if (busy !== m_owned) $display("FAIL %s busy_gap: got %b expected %b", tag, busy, m_owned);
    else n_pass++;
    if (drop && exp_ack >= 0) req_valid[exp_ack] = 1'b0;
    spi_cs = 1'b0;
    if (new_data) begin
      for (int i = 0; i < NR; i++) req_data[i*DL +: DL] = {$urandom, $urandom};
    end
    repeat (5) tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_window: got %b expected 1", tag, busy);
    else n_pass++;
    if (nframes == 0) begin
      repeat (35) tick();
    end else begin
      for (int f = 0; f < nframes; f++) begin
        mosi     = (f == 0) ? mosi0 : {$urandom, $urandom};
        exp_miso = (f == 0 && m_owned) ? m_word : m_fill();
        last     = (f == nframes - 1);
        if (last && sim_last) req_valid = next_valid;
        run_frame(mosi, exp_miso, last && sim_last, tag);
      end
      m_owned = 1'b0;
    end
    req_valid = next_valid;
    spi_cs    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    n_total++;
    if (spi_tx !== IW) $display("FAIL reset spi_tx: got %h expected %h", spi_tx, IW);
    else n_pass++;
    n_total++;
    if (req_ack !== '0 || rx_valid !== 1'b0)
      $display("FAIL reset strobes: got ack=%b rx_valid=%b expected 0/0", req_ack, rx_valid);
    else n_pass++;
    n_total++;
    if (rx_data !== '0 || frame_count !== 16'd0)
      $display("FAIL reset rx: got rx_data=%h count=%0d expected 0/0", rx_data, frame_count);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy);
    else n_pass++;
    ack_q.delete();
  endtask

  task automatic test_idle_frame();
    int unsigned p0;
    req_valid = '0;
    p0 = rx_pulses;
    run_window(1, 64'h0123_4567_89AB_CDEF, '0, 1'b0, 1'b0, 1'b0, "idle_frame");
    repeat (10) tick();
    n_total++;
    if (rx_pulses - p0 != 1) $display("FAIL idle_frame pulses: got %0d expected 1", rx_pulses - p0);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NR; i++) req_data[i*DL +: DL] = {$urandom, $urandom};
    req_valid = 4'b1010;
    run_window(1, {$urandom, $urandom}, 4'b1010, 1'b0, 1'b0, 1'b0, "rr_w1");
    run_window(1, {$urandom, $urandom}, 4'b1010, 1'b0, 1'b0, 1'b0, "rr_w2");
    run_window(1, {$urandom, $urandom}, 4'b1010, 1'b0, 1'b0, 1'b0, "rr_w3");
    run_window(1, {$urandom, $urandom}, 4'b0000, 1'b0, 1'b0, 1'b0, "rr_w4");
  endtask

  task automatic test_multi_frame();
    req_data[2*DL +: DL] = 64'h0000_0000_DEAD_BEEF;
    req_valid = 4'b0100;
    run_window(2, {$urandom, $urandom}, 4'b0000, 1'b1, 1'b0, 1'b0, "multi_frame");
  endtask

  task automatic test_partial();
    req_data[0 +: DL] = {$urandom, $urandom};
    req_valid = 4'b0001;
    run_window(0, '0, 4'b0001, 1'b0, 1'b0, 1'b0, "partial_open");
    run_window(1, {$urandom, $urandom}, 4'b0000, 1'b0, 1'b0, 1'b0, "partial_full");
  endtask

  task automatic test_simultaneous();
    req_data[1*DL +: DL] = {$urandom, $urandom};
    req_valid = 4'b0010;
    run_window(1, {$urandom, $urandom}, 4'b0000, 1'b1, 1'b1, 1'b0, "sim_edge");
    run_window(1, {$urandom, $urandom}, 4'b0000, 1'b0, 1'b0, 1'b0, "sim_after");
  endtask

  task automatic test_reset_active();
    int            exp_ack;
    int            first_ack;
    req_data[3*DL +: DL] = {$urandom, $urandom};
    req_valid = 4'b1000;
    exp_ack = rr_pick(m_last, req_valid);
    repeat (10) tick();
    first_ack = (ack_q.size() > 0) ? ack_q[0] : -1;
    n_total++;
    if (ack_q.size() != 1 || first_ack != exp_ack)
      $display("FAIL rst_active ack: got %0d acks first=%0d expected requester %0d",
               ack_q.size(), first_ack, exp_ack);
    else n_pass++;
    ack_q.delete();
    spi_cs = 1'b0;
    repeat (20) tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL rst_active busy_before: got %b expected 1", busy);
    else n_pass++;
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    model_reset();
    n_total++;
    if (spi_tx !== IW || busy !== 1'b0)
      $display("FAIL rst_active state: got tx=%h busy=%b expected %h/0", spi_tx, busy, IW);
    else n_pass++;
    n_total++;
    if (rx_data !== '0 || frame_count !== 16'd0 || rx_valid !== 1'b0 || req_ack !== '0)
      $display("FAIL rst_active outputs: got rx=%h count=%0d rxv=%b ack=%b expected zeros",
               rx_data, frame_count, rx_valid, req_ack);
    else n_pass++;
    repeat (10) tick();
    spi_cs = 1'b1;
    run_window(1, {$urandom, $urandom}, 4'b0000, 1'b0, 1'b0, 1'b0, "rst_next");
  endtask

`ifdef SPI_ARB_ECHO_EN
  task automatic test_echo();
    req_valid = '0;
    run_window(1, 64'h0000_0000_0000_5555, '0, 1'b0, 1'b0, 1'b0, "echo_rx");
    run_window(1, {$urandom, $urandom}, '0, 1'b0, 1'b0, 1'b0, "echo_tx");
  endtask
`endif

  task automatic test_random();
    logic [NR-1:0] nv;
    for (int i = 0; i < NR; i++) req_data[i*DL +: DL] = {$urandom, $urandom};
    req_valid = 4'b1111;
    for (int w = 0; w < 14; w++) begin
      nv = NR'($urandom_range(0, 15));
      run_window(int'($urandom_range(0, 2)), {$urandom, $urandom}, nv,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1, "random");
    end
    req_valid = '0;
    repeat (10) tick();
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rx_pulses = 0;
    rst       = 1'b1;
    spi_cs    = 1'b1;
    spi_ready = 1'b0;
    spi_rx    = '0;
    req_valid = '0;
    req_data  = '0;
    model_reset();
    test_reset();
    test_idle_frame();
    test_round_robin();
    test_multi_frame();
    test_partial();
    test_simultaneous();
    test_reset_active();
`ifdef SPI_ARB_ECHO_EN
    test_echo();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
